multi_hit_tdc: RTL and testbench
================================

# multi_hit_tdc

Multi-channel, multi-hit coarse TDC for the trigger front end. It time-stamps edges on N_CH asynchronous STOP inputs against the most recent asynchronous START (epoch) edge, in CLK periods. Hits are stored in a first-word-fall-through FIFO for the readout logic. It is the parametrised successor of the single-channel, single-hit TDC. It adds per-channel enables, edge-mode selection, multi-hit buffering and overflow/loss flags.

## Interface
- N_CH, 4: number of STOP channels (1..16); CH_W = max(1, clog2(N_CH))
- TIME_W, 8: timestamp width in CLK cycles
- FIFO_DEPTH, 16: hit FIFO depth (power of 2, ≥ 4)
- CLK  in  1  sole clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  asynchronous epoch input; rising edge restarts time base
- STOP  in  N_CH  asynchronous hit inputs
- CH_EN  in  N_CH  per-channel enable, synchronous to CLK
- MODE  in  2  00 off, 01 rising, 10 falling, 11 both edges
- CLR  in  1  synchronous clear of OVERFLOW and HIT_LOST
- RD  in  1  pop FIFO head; ignored when EMPTY
- DOUT  out  TIME_W+CH_W+2  FIFO head {SAT, EDGE, CH, TIME}; EDGE 1 = rising
- EMPTY  out  1  FIFO empty
- COUNT  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- OVERFLOW  out  1  sticky: a hit was dropped because the FIFO was full
- HIT_LOST  out  1  sticky: an edge was dropped because the channel pending slot was busy
- ARMED  out  1  set by the first START edge after reset

## Operation
- START and each STOP bit pass through a 2-flop synchroniser and a third delay flop. The edge strobe is formed combinationally from flops 2/3. Identical latency on all inputs cancels in the timestamp.
- Time base C (TIME_W bits, saturating):
  - START rising strobe: C <= 1, ARMED <= 1.
  - Otherwise C <= C+1 until all-ones, then it holds.
- Timestamp of a strobe in cycle t is 0 if the START strobe is also active in t, else C.
  - A STOP edge k cycles after a START edge yields TIME = k.
  - SAT = 1 if C is all-ones and there is no simultaneous START.
- Edge acceptance on channel i requires all of:
  - ARMED = 1
  - CH_EN[i] = 1
  - MODE selects that edge polarity
- Accepted edge → per-channel one-entry pending register {SAT, EDGE, TIME}.
  - If that channel's pending register is already full and is not being drained this cycle, the edge is dropped and HIT_LOST is set.
- Arbiter: each cycle, the lowest-index full pending register is written to the FIFO and cleared. One write per cycle.
  - FIFO full: the entry is discarded, the pending register is cleared, OVERFLOW is set.
- FIFO: FWFT. DOUT is valid whenever EMPTY = 0. RD & !EMPTY pops at the clock edge. Simultaneous write and pop leave COUNT unchanged.
- CLR clears OVERFLOW and HIT_LOST only. If a new loss occurs in the same cycle as CLR, the flag stays set.
- Changing MODE or CH_EN affects only edges strobed after the change. Pending and FIFO contents are kept.

## Timing
- Reset values:
  - DOUT = 0, EMPTY = 1, COUNT = 0, OVERFLOW = 0, HIT_LOST = 0, ARMED = 0
  - C = 0; all pending registers, synchronisers and FIFO pointers = 0
- RST mid-operation discards all pending and stored hits immediately. ARMED is 0 until the next START edge.
- Input to strobe: 2–3 CLK cycles, depending on sampling phase.
- Strobe in cycle t → pending at edge t+1 → FIFO write at end of t+1 → EMPTY = 0 in t+2.
  - With p full pending registers ahead in priority, the write is delayed by p cycles.
- Pop: DOUT shows the next entry in the cycle after RD.
- Edges on the same channel closer than 1 cycle apart (before synchroniser resolution) are not guaranteed. Edges ≥ 2 cycles apart are both recorded, provided the arbiter is not blocked by lower-index channels.

## Test plan
- Reset, START pulse, STOP[0] rising 5 cycles after the START strobe, MODE=01 → one word {SAT=0, EDGE=1, CH=0, TIME=5}; EMPTY deasserts 2 cycles after the STOP strobe.
- STOP[3] and STOP[1] strobed in the same cycle, T=9 → two words in order CH=1 then CH=3, both TIME=9; COUNT reaches 2.
- MODE=11, 3-cycle STOP[2] pulse starting at T=10 → words TIME=10 EDGE=1, then TIME=13 EDGE=0. MODE=10 on the same stimulus → only the TIME=13 word.
- No START after reset, STOP pulses → FIFO stays empty, ARMED = 0. START then no STOP for 300 cycles (TIME_W=8), then STOP → TIME=255, SAT=1.
- FIFO_DEPTH+2 hits with no RD → COUNT = FIFO_DEPTH, OVERFLOW = 1. CLR → OVERFLOW = 0. Draining returns the first FIFO_DEPTH hits in order.
- START strobe coincident with STOP[0] strobe → TIME=0. Assert RST while FIFO holds 3 words → EMPTY = 1, COUNT = 0 immediately.

Source files
------------

// File: rtl/multi_hit_tdc.sv
// multi_hit_tdc: multi-channel multi-hit coarse TDC with per-channel pending slots and an FWFT hit FIFO
module multi_hit_tdc #(
   parameter int N_CH = 4,
   parameter int TIME_W = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int DW = TIME_W + CH_W + 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [N_CH-1:0] stop,
   input  logic [N_CH-1:0] ch_en,
   input  logic [1:0]      mode,
   input  logic            clr,
   input  logic            rd,
   output logic [DW-1:0]   dout,
   output logic            empty,
   output logic [AW:0]     count,
   output logic            overflow,
   output logic            hit_lost,
   output logic            armed
);
   logic [2:0] st_s;
   logic [N_CH-1:0] sp1, sp2, sp3, rise, fall, acc, drop, pv, grant;
   logic [TIME_W+1:0] pd [N_CH];
   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [TIME_W-1:0] c, ts;
   logic [AW-1:0] wp, rp;
   logic [CH_W-1:0] gch;
   logic st_stb, sat, wr, full, push, pop;

   assign st_stb = st_s[1] & ~st_s[2];
   assign rise = sp2 & ~sp3;
   assign fall = ~sp2 & sp3;
   assign ts = st_stb ? '0 : c;
   assign sat = (&c) & ~st_stb;
   assign acc = {N_CH{armed}} & ch_en & ((rise & {N_CH{mode[0]}}) | (fall & {N_CH{mode[1]}}));
   assign drop = acc & pv & ~grant;
   assign wr = |pv;
   assign empty = count == '0;
   assign full = count == (AW+1)'(FIFO_DEPTH);
   assign push = wr & ~full;
   assign pop = rd & ~empty;
   assign dout = empty ? '0 : mem[rp];

   // scan from the top so the lowest-index full slot wins
   always_comb begin
      grant = '0;
      gch = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (pv[i]) begin
            grant = '0;
            grant[i] = 1'b1;
            gch = CH_W'(i);
         end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st_s <= '0;
         sp1 <= '0;
         sp2 <= '0;
         sp3 <= '0;
         c <= '0;
         armed <= 1'b0;
         pv <= '0;
         for (int i = 0; i < N_CH; i++) pd[i] <= '0;
         wp <= '0;
         rp <= '0;
         count <= '0;
         overflow <= 1'b0;
         hit_lost <= 1'b0;
      end else begin
         st_s <= {st_s[1:0], start};
         sp1 <= stop;
         sp2 <= sp1;
         sp3 <= sp2;
         c <= st_stb ? TIME_W'(1) : (&c) ? c : c + 1'b1;
         armed <= armed | st_stb;
         for (int i = 0; i < N_CH; i++)
            if (acc[i] & ~drop[i]) begin
               pv[i] <= 1'b1;
               pd[i] <= {sat, rise[i], ts};
            end else if (grant[i]) pv[i] <= 1'b0;
         wp <= wp + AW'(push);
         rp <= rp + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         overflow <= (overflow & ~clr) | (wr & full);
         hit_lost <= (hit_lost & ~clr) | (|drop);
      end

   always_ff @(posedge clk)
      if (push) mem[wp] <= {pd[gch][TIME_W+1:TIME_W], gch, pd[gch][TIME_W-1:0]};
endmodule

// File: tb/tb_multi_hit_tdc.sv
// tb_multi_hit_tdc: directed bench for multi_hit_tdc with N_CH=4, TIME_W=8, FIFO_DEPTH=16
module tb_multi_hit_tdc;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, clr = 1'b0, rd = 1'b0;
   logic [3:0] stop = '0, ch_en = '0;
   logic [1:0] mode = '0;
   logic [11:0] dout;
   logic empty, overflow, hit_lost, armed;
   logic [4:0] count;
   int errors = 0, checks = 0;

   multi_hit_tdc #(.N_CH(4), .TIME_W(8), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en), .mode(mode),
      .clr(clr), .rd(rd), .dout(dout), .empty(empty), .count(count),
      .overflow(overflow), .hit_lost(hit_lost), .armed(armed)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop();
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] w(input logic s, input logic e, input int ch, input int t);
      return {20'b0, s, e, ch[1:0], t[7:0]};
   endfunction

   initial begin
      cyc(2);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_count", 32'(count), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_hit_lost", 32'(hit_lost), 0);
      chk("rst_armed", 32'(armed), 0);
      rst = 1'b0;
      ch_en = 4'hf;
      mode = 2'b01;
      cyc(2);
      stop[0] = 1'b1;
      cyc(3);
      stop[0] = 1'b0;
      cyc(6);
      chk("unarmed_empty", 32'(empty), 1);
      chk("unarmed_armed", 32'(armed), 0);
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      cyc(3);
      stop[0] = 1'b1;
      cyc(3);
      chk("t5_empty_early", 32'(empty), 1);
      chk("t5_armed", 32'(armed), 1);
      cyc(1);
      chk("t5_empty", 32'(empty), 0);
      chk("t5_dout", 32'(dout), w(0, 1, 0, 5));
      chk("t5_count", 32'(count), 1);
      stop[0] = 1'b0;
      pop();
      chk("t5_pop_count", 32'(count), 0);
      cyc(4);
      chk("t5_fall_ignored", 32'(empty), 1);
      cyc(5);
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      cyc(7);
      stop = 4'b1010;
      cyc(4);
      chk("t9_count1", 32'(count), 1);
      chk("t9_head_ch1", 32'(dout), w(0, 1, 1, 9));
      cyc(1);
      chk("t9_count2", 32'(count), 2);
      chk("t9_head_kept", 32'(dout), w(0, 1, 1, 9));
      stop = 4'b0000;
      pop();
      chk("t9_ch3", 32'(dout), w(0, 1, 3, 9));
      chk("t9_count_after_pop", 32'(count), 1);
      pop();
      chk("t9_empty", 32'(empty), 1);
      cyc(5);
      mode = 2'b11;
      for (int m = 0; m < 2; m++) begin
         start = 1'b1;
         cyc(2);
         start = 1'b0;
         cyc(8);
         stop[2] = 1'b1;
         cyc(3);
         stop[2] = 1'b0;
         cyc(4);
         if (m == 0) begin
            chk("both_count", 32'(count), 2);
            chk("both_rise", 32'(dout), w(0, 1, 2, 10));
            pop();
            chk("both_fall", 32'(dout), w(0, 0, 2, 13));
            pop();
            chk("both_empty", 32'(empty), 1);
            cyc(5);
            mode = 2'b10;
         end else begin
            chk("fall_count", 32'(count), 1);
            chk("fall_only", 32'(dout), w(0, 0, 2, 13));
            pop();
            chk("fall_empty", 32'(empty), 1);
         end
      end
      cyc(5);
      mode = 2'b01;
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      cyc(298);
      stop[0] = 1'b1;
      cyc(4);
      chk("sat_count", 32'(count), 1);
      chk("sat_word", 32'(dout), w(1, 1, 0, 255));
      stop[0] = 1'b0;
      pop();
      cyc(5);
      mode = 2'b11;
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      cyc(1);
      repeat (18) begin
         stop[0] = ~stop[0];
         cyc(2);
      end
      cyc(4);
      chk("ovf_count", 32'(count), 16);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_no_loss", 32'(hit_lost), 0);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);
      chk("ovf_clr_count", 32'(count), 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain_%0d", i), 32'(dout), w(0, (i % 2) == 0, 0, 3 + 2 * i));
         pop();
      end
      chk("drain_empty", 32'(empty), 1);
      cyc(5);
      mode = 2'b01;
      start = 1'b1;
      stop[0] = 1'b1;
      cyc(2);
      start = 1'b0;
      cyc(2);
      chk("coinc_count", 32'(count), 1);
      chk("coinc_word", 32'(dout), w(0, 1, 0, 0));
      stop[0] = 1'b0;
      pop();
      chk("coinc_empty", 32'(empty), 1);
      cyc(5);
      mode = 2'b11;
      stop = 4'b0011;
      cyc(1);
      stop = 4'b0001;
      cyc(2);
      stop = 4'b0000;
      cyc(5);
      chk("lost_count", 32'(count), 3);
      chk("lost_flag", 32'(hit_lost), 1);
      chk("lost_no_ovf", 32'(overflow), 0);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      chk("lost_clr", 32'(hit_lost), 0);
      chk("lost_clr_count", 32'(count), 3);
      rst = 1'b1;
      #1;
      chk("arst_empty", 32'(empty), 1);
      chk("arst_count", 32'(count), 0);
      chk("arst_dout", 32'(dout), 0);
      chk("arst_armed", 32'(armed), 0);
      cyc(1);
      rst = 1'b0;
      cyc(3);
      chk("arst_stays_empty", 32'(empty), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
